// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared size codes, controller states and size helper
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Reserved size reports 4 bytes; it is rejected by the error check anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_read_align.sv
`default_nettype none
// ============================================================================
// dmem_read_align : big-endian byte/half/word extraction with sign extension
// Revision : 1.0
// ============================================================================
module dmem_read_align (
  input  logic [31:0] fetched,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] rdata
);
  import dmem_pkg::*;

  logic ext;

  // fetched[31:24] is the byte at the request address (most significant).
  always_comb begin
    ext = se & fetched[31];
    case (size)
      SIZE_BYTE: rdata = {{24{ext}}, fetched[31:24]};
      SIZE_HALF: rdata = {{16{ext}}, fetched[31:16]};
      default:   rdata = fetched;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_sync_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_sync_ctrl : handshaked big-endian data memory, one request in flight
// Revision : 1.0
// ============================================================================
module dmem_sync_ctrl #(
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LATENCY   = 1,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  import dmem_pkg::*;

  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [7:0]        mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              mem_we;
  logic              req_err;
  logic              misaligned;
  logic              out_of_range;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   last_addr;
  logic [ADDR_W-1:0] byte_addr [4];
  logic [7:0]        wbyte [4];
  logic [31:0]       fetched;
  logic [31:0]       aligned;

  assign req_ready = reset_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && req_rw && !req_err;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Byte addresses wrap inside the array; any access that would wrap is flagged out of range.
  always_comb begin
    nbytes       = size_bytes(req_size);
    last_addr    = {1'b0, req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    out_of_range = (last_addr >= (ADDR_W+1)'(DEPTH));
    misaligned   = (ALIGN_CHK != 0) &&
                   (((req_size == SIZE_HALF) && req_addr[0]) ||
                    ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)));
    req_err      = (req_size == SIZE_RSVD) || misaligned || out_of_range;
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = req_addr + ADDR_W'(i);
    end
    fetched = {mem[byte_addr[0]], mem[byte_addr[1]], mem[byte_addr[2]], mem[byte_addr[3]]};
  end

  always_comb begin
    wbyte[0] = req_wdata[31:24];
    wbyte[1] = req_wdata[23:16];
    wbyte[2] = req_wdata[15:8];
    wbyte[3] = req_wdata[7:0];
    case (req_size)
      SIZE_BYTE: begin
        wbyte[0] = req_wdata[7:0];
      end
      SIZE_HALF: begin
        wbyte[0] = req_wdata[15:8];
        wbyte[1] = req_wdata[7:0];
      end
      default: ;
    endcase
  end

  dmem_read_align u_read_align (
    .fetched (fetched),
    .size    (req_size),
    .se      (req_se),
    .rdata   (aligned)
  );

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nbytes) begin
          mem[byte_addr[i]] <= wbyte[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_rw || req_err) ? 32'd0 : aligned;
          err_d   = req_err;
          cnt_d   = WAIT_INIT;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire
